ping_pong_ctrl: RTL and testbench

Clocked initiator for a ping/pong round-trip handshake. It issues single-cycle ping pulses to a downstream responder and consumes the responder's pong pulses. It counts completed round trips and signals done after ROUNDS rounds, or flags an error if a pong does not arrive within TIMEOUT cycles. It is the driving stage that feeds the event-based ping/pong responder in the scheduler test suite.

---
 rtl/ping_pong_ctrl.sv | 117 +++++++++++
 tb/tb_ping_pong_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_ctrl.sv
// ----------------------------------------------------------------------------
// ping_pong_ctrl
//
// Initiator for a ping/pong round-trip handshake. It sends one-cycle ping
// pulses to a downstream responder and waits for a pong after each one. It
// counts completed round trips. After ROUNDS round trips it parks in DONE.
// If no pong arrives within TIMEOUT wait cycles, it parks in ERR instead.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        begin or restart a run (honoured in IDLE, DONE, ERR only)
//   pong         response pulse from the responder (honoured in WAIT only)
//   ping         request pulse, high for exactly one cycle per round
//   cnt          completed rounds in the current run
//   busy         high while a run is in progress (PING or WAIT)
//   done         high in DONE
//   timeout_err  high in ERR
//
// All outputs are decoded from registered state only. No input reaches an
// output combinationally.
// ----------------------------------------------------------------------------
module ping_pong_ctrl #(
  parameter int ROUNDS  = 10,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pong,
  output logic             ping,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PING = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ROUNDS_C     = CNT_W'(ROUNDS);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TO_W-1:0]  timer_reg, timer_next;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_reg + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
    end
  end

  // Next-state logic. cnt and timer update here too, so each counter
  // change stays tied to the transition that causes it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    unique case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_PING;
          cnt_next   = '0;
        end
      end
      S_PING: begin
        // The responder needs at least one cycle of latency, so a pong
        // seen here cannot belong to this ping.
        state_next = S_WAIT;
        timer_next = '0;
      end
      S_WAIT: begin
        // A pong beats a timeout in the same cycle. That means a pong is
        // accepted in every one of the TIMEOUT wait cycles.
        if (pong) begin
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == ROUNDS_C) ? S_DONE : S_PING;
        end else if (timer_reg == TIMEOUT_LAST) begin
          state_next = S_ERR;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    ping        = (state_reg == S_PING);
    busy        = (state_reg == S_PING) || (state_reg == S_WAIT);
    done        = (state_reg == S_DONE);
    timeout_err = (state_reg == S_ERR);
    cnt         = cnt_reg;
  end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ping_pong_ctrl (ROUNDS=10, TIMEOUT=16).
// A responder model echoes ping after a programmable latency. A separate
// manual pong drive covers boundary and spurious-pulse cases.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ping_pong_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pong;
  logic       ping;
  logic [7:0] cnt;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // responder model
  logic       resp_en = 1'b0;
  logic       pong_man = 1'b0;
  int         lat = 1;
  logic [7:0] pipe_reg = '0;

  always #5 clk = ~clk;

  ping_pong_ctrl #(
    .ROUNDS(10), .CNT_W(8), .TIMEOUT(16), .TO_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pong(pong),
    .ping(ping), .cnt(cnt), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always @(posedge clk) pipe_reg <= {pipe_reg[6:0], ping & resp_en};

  always_comb begin
    pong = pong_man | (resp_en & pipe_reg[lat-1]);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step n cycles and return how many of the sampled cycles had ping high.
  task automatic run(input int n, output int pings);
    pings = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ping) pings++;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " ping"}, 32'(ping), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " err"},  32'(timeout_err), 0);
    check({tag, " cnt"},  32'(cnt), 0);
  endtask

  initial begin
    int np;

    // ---------------- reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle_zero("reset");

    // ---------------- L=1, full run
    lat = 1; resp_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("l1 first ping", 32'(ping), 1);
    check("l1 busy", 32'(busy), 1);
    run(10, np);
    check("l1 cnt mid", 32'(cnt), 5);
    check("l1 pings mid", 32'(np), 5);
    run(9, np);
    check("l1 pings late", 32'(np), 4);
    check("l1 done early", 32'(done), 0);
    tick();
    check("l1 done at 20", 32'(done), 1);
    check("l1 cnt final", 32'(cnt), 10);
    check("l1 busy final", 32'(busy), 0);
    run(5, np);
    check("l1 no ping after done", 32'(np), 0);
    check("l1 done sticky", 32'(done), 1);

    // ---------------- L=3, restart from DONE
    lat = 3;
    start = 1'b1; tick(); start = 1'b0;
    check("l3 restart ping", 32'(ping), 1);
    check("l3 restart cnt", 32'(cnt), 0);
    run(39, np);
    check("l3 pings", 32'(np), 9);
    check("l3 done early", 32'(done), 0);
    tick();
    check("l3 done at 40", 32'(done), 1);
    check("l3 cnt", 32'(cnt), 10);

    // ---------------- no responder -> timeout
    resp_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("to ping", 32'(ping), 1);
    run(16, np);
    check("to err early", 32'(timeout_err), 0);
    check("to busy at 16", 32'(busy), 1);
    tick();
    check("to err at 17", 32'(timeout_err), 1);
    check("to cnt", 32'(cnt), 0);
    check("to busy", 32'(busy), 0);
    run(5, np);
    check("to no ping", 32'(np), 0);

    // ---------------- boundary: pong in the 16th WAIT cycle, then in the 17th
    start = 1'b1; tick(); start = 1'b0;
    run(16, np);
    pong_man = 1'b1; tick(); pong_man = 1'b0;
    check("bnd accepted cnt", 32'(cnt), 1);
    check("bnd accepted ping", 32'(ping), 1);
    check("bnd no err", 32'(timeout_err), 0);
    tick();
    run(15, np);
    check("bnd err before 17", 32'(timeout_err), 0);
    tick();
    check("bnd err at 17", 32'(timeout_err), 1);
    pong_man = 1'b1; tick(); pong_man = 1'b0;
    check("bnd late pong cnt", 32'(cnt), 1);
    check("bnd late pong err", 32'(timeout_err), 1);
    check("bnd late pong busy", 32'(busy), 0);

    // ---------------- reset mid-run
    lat = 1; resp_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    run(10, np);
    check("mid cnt", 32'(cnt), 5);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    check_idle_zero("mid rst");
    tick();
    check("mid stays idle", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    run(19, np);
    check("post rst pings", 32'(np), 9);
    tick();
    check("post rst done", 32'(done), 1);
    check("post rst cnt", 32'(cnt), 10);

    // ---------------- spurious start/pong
    rst = 1'b1; tick(); rst = 1'b0;
    resp_en = 1'b0;
    pong_man = 1'b1; tick(); pong_man = 1'b0;
    check("sp idle pong busy", 32'(busy), 0);
    check("sp idle pong cnt", 32'(cnt), 0);
    start = 1'b1; tick();
    check("sp ping", 32'(ping), 1);
    pong_man = 1'b1; tick(); pong_man = 1'b0;   // pong in PING, start held
    check("sp pong in ping cnt", 32'(cnt), 0);
    check("sp wait busy", 32'(busy), 1);
    check("sp wait ping", 32'(ping), 0);
    tick();                                      // start while busy
    start = 1'b0;
    check("sp start busy cnt", 32'(cnt), 0);
    check("sp start busy ping", 32'(ping), 0);
    resp_en = 1'b1;
    pong_man = 1'b1; tick(); pong_man = 1'b0;
    check("sp real pong cnt", 32'(cnt), 1);
    check("sp real pong ping", 32'(ping), 1);
    run(17, np);
    check("sp done early", 32'(done), 0);
    tick();
    check("sp done", 32'(done), 1);
    check("sp cnt", 32'(cnt), 10);
    start = 1'b1; tick(); start = 1'b0;
    check("sp restart ping", 32'(ping), 1);
    check("sp restart cnt", 32'(cnt), 0);
    check("sp restart done", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
